// File: rtl/tile_pkg.sv
// Shared types for the tile hash front end: FSM states, sizes and the captured result record.
package tile_pkg;

   localparam int TILE_WORDS = 8;
   localparam int HASH_W     = 16;
   localparam int IDX_W      = 10;

   typedef enum logic [1:0] {
      ST_ACCUM,
      ST_ISSUE,
      ST_WAIT_LK,
      ST_RESULT
   } state_e;

   typedef struct packed {
      logic              match;
      logic              blank;
      logic              timeout;
      logic [7:0]        code;
      logic [15:0]       ptr;
      logic [HASH_W-1:0] hash;
      logic [IDX_W-1:0]  idx;
   } tile_res_t;

endpackage

// File: rtl/tile_hash_fold.sv
// One hash step: rotate the running hash left by one and fold in both halves of the word.
module tile_hash_fold
   import tile_pkg::*;
(
   input  logic [HASH_W-1:0] h_i,
   input  logic [31:0]       w_i,
   output logic [HASH_W-1:0] h_o
);

   assign h_o = {h_i[HASH_W-2:0], h_i[HASH_W-1]} ^ w_i[31:16] ^ w_i[15:0];

endmodule

// File: rtl/tile_hash_frontend.sv
// Folds 8-word tiles into a hash, issues one lookup per non-blank tile and holds one tagged
// result per tile until it is consumed downstream. Tiles are processed strictly one at a time.
module tile_hash_frontend
   import tile_pkg::*;
#(
   parameter int          WORDS_PER_TILE = TILE_WORDS,
   parameter logic [31:0] BLANK_WORD     = 32'h0,
   parameter int          TIMEOUT_CYCLES = 64,
   parameter int          IDX_BITS       = IDX_W
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                tile_valid_i,
   output logic                tile_ready_o,
   input  logic [31:0]         tile_data_i,
   input  logic                tile_last_i,
   output logic                hash_valid_o,
   output logic [HASH_W-1:0]   hash_out_o,
   input  logic                lookup_done_i,
   input  logic                match_found_i,
   input  logic [7:0]          char_code_i,
   input  logic [15:0]         translation_ptr_i,
   output logic                res_valid_o,
   input  logic                res_ready_i,
   output logic                res_match_o,
   output logic                res_blank_o,
   output logic                res_timeout_o,
   output logic [7:0]          res_char_code_o,
   output logic [15:0]         res_trans_ptr_o,
   output logic [HASH_W-1:0]   res_hash_o,
   output logic [IDX_BITS-1:0] res_tile_idx_o,
   output logic                err_framing_o
);

   localparam int CNT_W = $clog2(WORDS_PER_TILE);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [HASH_W-1:0]   h_q, h_d, h_fold;
   logic                blank_q, blank_d;
   logic                resync_q, resync_d;
   logic                err_q, err_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [IDX_BITS-1:0] idx_q, idx_d;
   tile_res_t           res_q, res_d;
   logic                word_acc, last_pos, word_blank;

   tile_hash_fold u_fold (
      .h_i (h_q),
      .w_i (tile_data_i),
      .h_o (h_fold)
   );

   assign word_acc   = tile_valid_i && tile_ready_o;
   assign last_pos   = (cnt_q == CNT_W'(WORDS_PER_TILE - 1));
   assign word_blank = blank_q && (tile_data_i == BLANK_WORD);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      h_d          = h_q;
      blank_d      = blank_q;
      resync_d     = resync_q;
      err_d        = err_q;
      tmr_d        = tmr_q;
      idx_d        = idx_q;
      res_d        = res_q;
      tile_ready_o = 1'b0;
      hash_valid_o = 1'b0;
      case (state_q)
         ST_ACCUM: begin
            tile_ready_o = 1'b1;
            if (word_acc) begin
               if (resync_q) begin
                  // Dropping the tail of a tile whose final word lacked tile_last.
                  if (tile_last_i) resync_d = 1'b0;
               end else if (last_pos && tile_last_i) begin
                  h_d     = h_fold;
                  blank_d = word_blank;
                  if (word_blank) begin
                     res_d         = '0;
                     res_d.blank   = 1'b1;
                     res_d.hash    = h_fold;
                     res_d.idx     = IDX_W'(idx_q);
                     state_d       = ST_RESULT;
                  end else begin
                     state_d = ST_ISSUE;
                  end
               end else if (tile_last_i || last_pos) begin
                  err_d    = 1'b1;
                  cnt_d    = '0;
                  h_d      = '0;
                  blank_d  = 1'b1;
                  resync_d = !tile_last_i;
               end else begin
                  h_d     = h_fold;
                  blank_d = word_blank;
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            hash_valid_o = 1'b1;
            tmr_d        = '0;
            state_d      = ST_WAIT_LK;
         end
         ST_WAIT_LK: begin
            if (lookup_done_i) begin
               res_d       = '0;
               res_d.match = match_found_i;
               res_d.code  = match_found_i ? char_code_i : 8'h0;
               res_d.ptr   = match_found_i ? translation_ptr_i : 16'h0;
               res_d.hash  = h_q;
               res_d.idx   = IDX_W'(idx_q);
               state_d     = ST_RESULT;
            end else if (int'(tmr_q) + 1 >= TIMEOUT_CYCLES - 1) begin
               // Result lands exactly TIMEOUT_CYCLES cycles after the request pulse.
               res_d         = '0;
               res_d.timeout = 1'b1;
               res_d.hash    = h_q;
               res_d.idx     = IDX_W'(idx_q);
               state_d       = ST_RESULT;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         ST_RESULT: begin
            if (res_ready_i) begin
               idx_d   = idx_q + 1'b1;
               h_d     = '0;
               blank_d = 1'b1;
               cnt_d   = '0;
               state_d = ST_ACCUM;
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_ACCUM;
         cnt_q    <= '0;
         h_q      <= '0;
         blank_q  <= 1'b1;
         resync_q <= 1'b0;
         err_q    <= 1'b0;
         tmr_q    <= '0;
         idx_q    <= '0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         h_q      <= h_d;
         blank_q  <= blank_d;
         resync_q <= resync_d;
         err_q    <= err_d;
         tmr_q    <= tmr_d;
         idx_q    <= idx_d;
         res_q    <= res_d;
      end
   end

   assign hash_out_o      = hash_valid_o ? h_q : '0;
   assign res_valid_o     = (state_q == ST_RESULT);
   assign res_match_o     = res_q.match;
   assign res_blank_o     = res_q.blank;
   assign res_timeout_o   = res_q.timeout;
   assign res_char_code_o = res_q.code;
   assign res_trans_ptr_o = res_q.ptr;
   assign res_hash_o      = res_q.hash;
   assign res_tile_idx_o  = res_q.idx[IDX_BITS-1:0];
   assign err_framing_o   = err_q;

endmodule

// File: tb/tb_tile_hash_frontend.sv
// Randomised scoreboard bench for tile_hash_frontend: a word-stream reference model queues
// expected hashes/results, independent monitors compare whatever the DUT presents.
module tb_tile_hash_frontend;
   import tile_pkg::*;

   localparam int TMO = 64;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        tile_valid = 1'b0, tile_last = 1'b0, tile_ready;
   logic [31:0] tile_data = '0;
   logic        hash_valid;
   logic [15:0] hash_out;
   logic        lookup_done = 1'b0, match_found = 1'b0;
   logic [7:0]  char_code = '0;
   logic [15:0] translation_ptr = '0;
   logic        res_valid, res_ready = 1'b0;
   logic        res_match, res_blank, res_timeout, err_framing;
   logic [7:0]  res_char_code;
   logic [15:0] res_trans_ptr, res_hash;
   logic [9:0]  res_tile_idx;

   tile_hash_frontend dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .tile_valid_i(tile_valid), .tile_ready_o(tile_ready), .tile_data_i(tile_data), .tile_last_i(tile_last),
      .hash_valid_o(hash_valid), .hash_out_o(hash_out),
      .lookup_done_i(lookup_done), .match_found_i(match_found), .char_code_i(char_code),
      .translation_ptr_i(translation_ptr),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_match_o(res_match), .res_blank_o(res_blank),
      .res_timeout_o(res_timeout), .res_char_code_o(res_char_code), .res_trans_ptr_o(res_trans_ptr),
      .res_hash_o(res_hash), .res_tile_idx_o(res_tile_idx), .err_framing_o(err_framing)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        match, blank, timeout;
      logic [7:0]  code;
      logic [15:0] ptr, hash;
      int          idx;
      int          kind;  // 0 blank, 1 answered lookup, 2 timeout
   } exp_t;

   int          checks = 0, errors = 0;
   longint      cyc = 0, last_acc_cyc = 0, hv_cyc = 0, done_cyc = 0;
   exp_t        exq[$];
   logic [15:0] hq[$];
   int          n_exp = 0, n_done = 0;
   logic [31:0] mdl_q[$];
   bit          mdl_resync = 0, mdl_err = 0;
   int          mdl_idx = 0;
   bit          lk_silent = 0, fast_ready = 1;
   int          lk_delay = 1, stall_left = 0;
   logic        lk_match = 0;
   logic [7:0]  lk_code = '0;
   logic [15:0] lk_ptr = '0;
   bit          in_res = 0;
   logic [52:0] snap;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_hash(input logic [31:0] ws[$]);
      logic [15:0] h;
      h = 16'h0;
      foreach (ws[i]) h = ((h << 1) | (h >> 15)) ^ ws[i][31:16] ^ ws[i][15:0];
      return h;
   endfunction

   task automatic model_complete();
      exp_t e;
      bit   blank;
      blank = 1;
      foreach (mdl_q[i]) if (mdl_q[i] != 32'h0) blank = 0;
      e = '{match: 0, blank: 0, timeout: 0, code: 8'h0, ptr: 16'h0, hash: ref_hash(mdl_q), idx: mdl_idx, kind: 0};
      mdl_idx = (mdl_idx + 1) % 1024;
      if (blank) e.blank = 1;
      else begin
         hq.push_back(e.hash);
         if (lk_silent) begin
            e.kind = 2; e.timeout = 1;
         end else begin
            e.kind = 1; e.match = lk_match;
            e.code = lk_match ? lk_code : 8'h0;
            e.ptr  = lk_match ? lk_ptr : 16'h0;
         end
      end
      exq.push_back(e);
      n_exp++;
      last_acc_cyc = cyc;
      mdl_q.delete();
   endtask

   task automatic model_word(input logic [31:0] w, input logic last);
      if (mdl_resync) begin
         if (last) mdl_resync = 0;
         return;
      end
      mdl_q.push_back(w);
      if (last && mdl_q.size() == 8) model_complete();
      else if (last || mdl_q.size() == 8) begin
         mdl_err = 1;
         mdl_resync = !last;
         mdl_q.delete();
      end
   endtask

   task automatic send_word(input logic [31:0] w, input logic last);
      int guard;
      guard = 0;
      tile_valid = 1; tile_data = w; tile_last = last;
      forever begin
         @(negedge clk);
         if (tile_ready === 1'b1) begin
            model_word(w, last);
            @(posedge clk); #1;
            break;
         end
         guard++;
         if (guard > 2000) begin
            checks++; errors++;
            $display("FAIL tile_ready_wait: got 0 expected 1 within 2000 cycles");
            break;
         end
         @(posedge clk); #1;
      end
      tile_valid = 0; tile_last = 0;
   endtask

   task automatic send_tile(input logic [31:0] ws [8], input bit gaps);
      for (int i = 0; i < 8; i++) begin
         send_word(ws[i], i == 7);
         if (gaps && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_done();
      int g;
      g = 0;
      while (n_done != n_exp && g < 3000) begin
         @(posedge clk); g++;
      end
      #1;
      chk("results_drained", 128'(n_done), 128'(n_exp));
   endtask

   task automatic do_reset(input string name);
      #1 rst_n = 0;
      tile_valid = 0; tile_last = 0; lookup_done = 0;
      repeat (2) @(posedge clk);
      exq.delete(); hq.delete(); mdl_q.delete();
      mdl_resync = 0; mdl_err = 0; mdl_idx = 0; n_exp = 0; n_done = 0;
      @(negedge clk);
      chk(name, {tile_ready, hash_valid, hash_out, res_valid, res_match, res_blank, res_timeout,
                 res_char_code, res_trans_ptr, res_hash, res_tile_idx, err_framing},
          128'({1'b1, 72'b0}));
      @(posedge clk); #1 rst_n = 1;
   endtask

   task automatic stray_done(input string name);
      @(posedge clk); #1;
      lookup_done = 1; match_found = 1; char_code = 8'h5A; translation_ptr = 16'hBEEF;
      @(posedge clk); #1;
      lookup_done = 0;
      repeat (4) @(posedge clk);
      #1 chk(name, {res_valid, hash_valid, tile_ready}, 3'b001);
   endtask

   // lookup stage model
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && hash_valid === 1'b1 && !lk_silent) begin
            repeat (lk_delay) @(posedge clk);
            #1;
            lookup_done = 1; match_found = lk_match; char_code = lk_code; translation_ptr = lk_ptr;
            done_cyc = cyc;
            @(posedge clk); #1;
            lookup_done = 0; match_found = 1'($urandom); char_code = 8'($urandom);
            translation_ptr = 16'($urandom);
         end
      end
   end

   // downstream ready
   initial begin
      forever begin
         @(posedge clk); #1;
         if (stall_left > 0 && res_valid === 1'b1) begin
            res_ready = 0; stall_left--;
         end else res_ready = fast_ready ? 1'b1 : 1'($urandom);
      end
   end

   // monitor
   initial begin
      exp_t        e;
      logic [15:0] h;
      longint      lat;
      forever begin
         @(negedge clk);
         if (!rst_n) in_res = 0;
         else begin
            if (hash_valid === 1'b1) begin
               hv_cyc = cyc;
               if (hq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_hash_valid: got 1 expected 0 (hash %0h)", hash_out);
               end else begin
                  h = hq.pop_front();
                  chk("hash_out", 128'(hash_out), 128'(h));
                  chk("hash_latency", 128'(cyc), 128'(last_acc_cyc + 1));
               end
            end
            if (res_valid === 1'b1) begin
               chk("tile_ready_during_result", 128'(tile_ready), 128'(0));
               if (!in_res) begin
                  snap = {res_match, res_blank, res_timeout, res_char_code, res_trans_ptr, res_hash, res_tile_idx};
                  if (exq.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL unexpected_res_valid: got 1 expected 0 (fields %0h)", snap);
                  end else begin
                     e = exq.pop_front();
                     chk("res_fields", 128'(snap),
                         128'({e.match, e.blank, e.timeout, e.code, e.ptr, e.hash, 10'(e.idx)}));
                     lat = (e.kind == 0) ? last_acc_cyc + 1 : (e.kind == 1) ? done_cyc + 1 : hv_cyc + TMO;
                     chk("res_latency", 128'(cyc), 128'(lat));
                  end
                  in_res = 1;
               end else begin
                  chk("res_stable", 128'({res_match, res_blank, res_timeout, res_char_code, res_trans_ptr,
                                          res_hash, res_tile_idx}), 128'(snap));
               end
               if (res_ready === 1'b1) begin
                  n_done++; in_res = 0;
               end
            end else in_res = 0;
         end
      end
   end

   initial begin
      logic [31:0] t [8];
      do_reset("reset_state");

      // known vectors
      t = '{default: 32'h0}; t[0] = 32'h0001_0000;
      lk_silent = 0; lk_delay = 3; lk_match = 1; lk_code = 8'h42; lk_ptr = 16'h1234;
      send_tile(t, 0); wait_done();
      t = '{default: 32'h0}; t[7] = 32'h0000_ABCD;
      lk_delay = 5; lk_match = 0; lk_code = 8'h77; lk_ptr = 16'h9999;
      send_tile(t, 0); wait_done();
      t = '{default: 32'h0};
      send_tile(t, 0); wait_done();

      // timeout, then a stray answer
      t = '{default: 32'h0}; t[3] = 32'hDEAD_BEEF;
      lk_silent = 1;
      send_tile(t, 0); wait_done();
      stray_done("stray_after_timeout");
      lk_silent = 0;

      // early tile_last, then a clean tile
      chk("err_before_framing", 128'(err_framing), 128'(0));
      for (int i = 0; i < 6; i++) send_word(32'h100 + i, i == 5);
      repeat (3) @(posedge clk);
      #1 chk("err_early_last", 128'(err_framing), 128'(mdl_err));
      foreach (t[i]) t[i] = $urandom;
      lk_delay = 7; lk_match = 1; lk_code = 8'h11; lk_ptr = 16'h2222;
      send_tile(t, 0); wait_done();

      // final word without tile_last: resync through next tile_last
      for (int i = 0; i < 8; i++) send_word(32'h55 + i, 1'b0);
      for (int i = 0; i < 3; i++) send_word(32'hAA + i, i == 2);
      foreach (t[i]) t[i] = $urandom;
      send_tile(t, 0); wait_done();
      chk("err_sticky", 128'(err_framing), 128'(1));

      // downstream back-pressure
      stall_left = 20;
      foreach (t[i]) t[i] = $urandom;
      send_tile(t, 0); wait_done();

      // randomised tiles
      fast_ready = 0;
      for (int n = 0; n < 40; n++) begin
         foreach (t[i]) t[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         if ($urandom_range(0, 5) == 0) t = '{default: 32'h0};
         lk_silent = ($urandom_range(0, 7) == 0);
         lk_delay  = $urandom_range(1, 40);
         lk_match  = 1'($urandom); lk_code = 8'($urandom); lk_ptr = 16'($urandom);
         send_tile(t, 1); wait_done();
      end

      // reset while waiting on the lookup
      t = '{default: 32'h0}; t[1] = 32'h1234_5678;
      lk_silent = 1;
      send_tile(t, 0);
      repeat (10) @(posedge clk);
      do_reset("reset_in_wait");
      stray_done("stray_after_reset");
      lk_silent = 0;

      // tile index wrap
      fast_ready = 1;
      t = '{default: 32'h0};
      for (int n = 0; n < 1030; n++) begin
         send_tile(t, 0); wait_done();
      end
      chk("err_after_run", 128'(err_framing), 128'(mdl_err));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
